// File: rtl/if_pkg.sv
// Shared types for the instruction fetch queue: reset PC default, fetch FSM
// encoding and the buffered {pc, instruction} entry.
package if_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instn;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO of fetched {pc, instruction} entries; flush overrides push/pop.
module if_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    do_pop  = pop & ~empty & ~flush;
    do_push = push & ~flush & (~full | do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: one-outstanding imem fetch FSM feeding a small
// instruction FIFO drained by decode; redirect flushes and restarts fetch.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instn_valid,
  output logic [31:0] instn,
  output logic [31:0] instn_pc,
  input  logic        id_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t   state;
  fetch_state_t   state_nxt;
  logic           run;
  logic [31:0]    pc;
  logic [31:0]    req_pc;
  logic           granted;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  fetch_entry_t   fifo_head;
  fetch_entry_t   fifo_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      // A response landing in the redirect cycle is discarded and also retires
      // the outstanding request, otherwise DROP would wait for a second rvalid.
      if (state != IDLE) state_nxt = imem_rvalid ? IDLE : DROP;
    end else begin
      case (state)
        IDLE:    if (granted) state_nxt = WAIT;
        WAIT:    if (imem_rvalid) state_nxt = IDLE;
        DROP:    if (imem_rvalid) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req    = run && (state == IDLE) && (fifo_count < DEPTH_C) && !redirect;
    granted     = imem_req & imem_gnt;
    push        = (state == WAIT) & imem_rvalid & ~redirect;
    instn_valid = ~fifo_empty & ~redirect;
    pop         = instn_valid & id_ready;
    instn       = instn_valid ? fifo_head.instn : '0;
    instn_pc    = instn_valid ? fifo_head.pc : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      run <= 1'b1;
      if (redirect) begin
        pc <= word_align(redirect_pc);
      end else if (granted) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end
    end
  end

  assign imem_addr = pc;
  assign fifo_in   = '{pc: req_pc, instn: imem_rdata};

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .entry (fifo_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  a_fifo_flags : assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_full == (fifo_count == DEPTH_C)) && (fifo_empty == (fifo_count == '0)));

endmodule
